// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core pipeline control logic:
// forwarding select encodings, hazard FSM state encoding and register address width.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forwarding select for one source operand.
// The M stage holds the younger result, so it wins over W.
module fwd_sel
    import core_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output fwd_sel_t              sel
);

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 core: forwarding selects,
// load-use / control-hazard stall and flush, and the multi-cycle mul/div handshake.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  ResultSrcE0,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  PCSrcE,
    input  logic                  MdReqE,
    input  logic                  MdDone,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MdStart,
    output logic                  MdErr,
    output logic [CNT_W-1:0]      StallCnt
);

    localparam int                TCNT_W    = $clog2(MD_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MD_TIMEOUT - 1);

    logic [0:0]        state;
    logic [TCNT_W-1:0] tcnt;
    logic              lw_stall;
    logic              busy;
    logic              md_timeout;
    logic              busy_release;

    fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardAE)
    );

    fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (ForwardBE)
    );

    assign lw_stall     = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // While rst is high the outputs behave as RUN even if the state register still says BUSY.
    assign busy         = (state == ST_BUSY) && !rst;
    assign md_timeout   = (tcnt == TCNT_LAST);
    assign busy_release = MdDone || md_timeout;

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (busy) begin
            StallF = !busy_release;
            StallD = !busy_release;
            StallE = !busy_release;
        end else begin
            StallF = lw_stall || MdReqE;
            StallD = lw_stall || MdReqE;
            StallE = MdReqE;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // MdReqE in the release cycle belongs to the instruction leaving E, so only RUN may start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            tcnt     <= '0;
            MdStart  <= 1'b0;
            MdErr    <= 1'b0;
            StallCnt <= '0;
        end else begin
            MdStart <= 1'b0;
            if (StallF && (StallCnt != '1)) begin
                StallCnt <= StallCnt + CNT_W'(1);
            end
            if (state == ST_RUN) begin
                if (MdReqE) begin
                    MdStart <= 1'b1;
                    state   <= ST_BUSY;
                    tcnt    <= '0;
                end
            end else begin
                if (MdDone) begin
                    state <= ST_RUN;
                end else if (md_timeout) begin
                    MdErr <= 1'b1;
                    state <= ST_RUN;
                end else begin
                    tcnt <= tcnt + TCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       ld, rw_m, rw_w, pc_src, md_req, md_done;
    } stim_t;

    typedef struct packed {
        logic [1:0] fwd_a, fwd_b;
        logic       stall_f, stall_d, stall_e, flush_d, flush_e;
        logic       md_start, md_err;
        logic [3:0] stall_cnt;
    } resp_t;

    typedef struct {
        string name;
        resp_t exp;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MdReqE, MdDone;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, MdStart, MdErr;
    logic [3:0] StallCnt;

    sb_item_t exp_q[$];
    int       n_compared = 0;
    int       n_mismatched = 0;

    hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .ResultSrcE0 (ResultSrcE0),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .PCSrcE      (PCSrcE),
        .MdReqE      (MdReqE),
        .MdDone      (MdDone),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .MdStart     (MdStart),
        .MdErr       (MdErr),
        .StallCnt    (StallCnt)
    );

    always #5 clk = ~clk;

    function automatic resp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                                 input logic sf, input logic sd, input logic se,
                                 input logic fd, input logic fe, input logic ms,
                                 input logic me, input logic [3:0] cnt);
        return '{fa, fb, sf, sd, se, fd, fe, ms, me, cnt};
    endfunction

    task automatic drive(input stim_t s);
        rst         = s.rst;
        Rs1D        = s.rs1_d;
        Rs2D        = s.rs2_d;
        Rs1E        = s.rs1_e;
        Rs2E        = s.rs2_e;
        RdE         = s.rd_e;
        RdM         = s.rd_m;
        RdW         = s.rd_w;
        ResultSrcE0 = s.ld;
        RegWriteM   = s.rw_m;
        RegWriteW   = s.rw_w;
        PCSrcE      = s.pc_src;
        MdReqE      = s.md_req;
        MdDone      = s.md_done;
    endtask

    // One vector per clock cycle; the expectation describes that same cycle's outputs.
    task automatic applyStimulus(input string name, input stim_t s, input resp_t e);
        sb_item_t it;
        @(posedge clk);
        #1;
        drive(s);
        it.name = name;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic checkOutput(input sb_item_t it);
        resp_t act;
        act = '{ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
                MdStart, MdErr, StallCnt};
        n_compared++;
        if (act !== it.exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got fA=%b fB=%b sFDE=%b%b%b flDE=%b%b start=%b err=%b cnt=%0d, want fA=%b fB=%b sFDE=%b%b%b flDE=%b%b start=%b err=%b cnt=%0d",
                     it.name, act.fwd_a, act.fwd_b, act.stall_f, act.stall_d, act.stall_e,
                     act.flush_d, act.flush_e, act.md_start, act.md_err, act.stall_cnt,
                     it.exp.fwd_a, it.exp.fwd_b, it.exp.stall_f, it.exp.stall_d, it.exp.stall_e,
                     it.exp.flush_d, it.exp.flush_e, it.exp.md_start, it.exp.md_err, it.exp.stall_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        stim_t s;
        stim_t lw;
        stim_t md;
        s = '0;
        s.rst = 1'b1;
        drive(s);
        repeat (2) @(posedge clk);

        applyStimulus("reset", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));

        s = '0; s.rs1_e = 5'd5; s.rd_m = 5'd5; s.rw_m = 1; s.rd_w = 5'd5; s.rw_w = 1;
        applyStimulus("fwdA_M", s, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        s.rw_m = 0;
        applyStimulus("fwdA_W", s, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        s.rw_m = 1; s.rd_m = 5'd0; s.rd_w = 5'd0;
        applyStimulus("fwdA_x0", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        s = '0; s.rs1_e = 5'd3; s.rs2_e = 5'd9; s.rd_m = 5'd9; s.rw_m = 1; s.rd_w = 5'd3; s.rw_w = 1;
        applyStimulus("fwdB_M_A_W", s, mk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        s = '0; s.rs2_e = 5'd9; s.rd_m = 5'd9; s.rd_w = 5'd9;
        applyStimulus("fwd_noWrite", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));

        lw = '0; lw.ld = 1; lw.rd_e = 5'd7; lw.rs2_d = 5'd7;
        applyStimulus("lwStall_rs2", lw, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 4'd0));
        s = '0; s.ld = 1;
        applyStimulus("lw_rdE0", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd1));
        s = '0; s.ld = 1; s.rd_e = 5'd4; s.rs1_d = 5'd4;
        applyStimulus("lwStall_rs1", s, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 4'd1));
        s = lw; s.pc_src = 1;
        applyStimulus("branch_lw", s, mk(2'b00, 2'b00, 1, 1, 0, 1, 1, 0, 0, 4'd2));
        s = '0; s.pc_src = 1;
        applyStimulus("branch", s, mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 4'd3));

        md = '0; md.md_req = 1;
        applyStimulus("md_req", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'd3));
        s = lw; s.md_req = 1; s.pc_src = 1;
        applyStimulus("md_busy_ignore", s, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 4'd4));
        applyStimulus("md_busy1", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'd5));
        applyStimulus("md_busy2", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'd6));
        applyStimulus("md_busy3", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'd7));
        s = md; s.md_done = 1;
        applyStimulus("md_done", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd8));
        applyStimulus("md_no_restart", '0, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd8));
        s = '0; s.md_done = 1;
        applyStimulus("md_done_in_run", s, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd8));

        applyStimulus("to_req", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0, 4'd8));
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("to_busy%0d", i), md,
                          mk(2'b00, 2'b00, 1, 1, 1, 0, 0, (i == 0), 0, 4'(9 + i)));
        end
        applyStimulus("to_release", md, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd15));
        applyStimulus("to_err_set", '0, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'd15));
        applyStimulus("sat_hold0", lw, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 4'd15));
        applyStimulus("sat_hold1", lw, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1, 4'd15));
        applyStimulus("err_sticky", '0, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'd15));

        applyStimulus("req_before_rst", md, mk(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 1, 4'd15));
        s = md; s.rst = 1; s.pc_src = 1;
        applyStimulus("rst_mid_busy", s, mk(2'b00, 2'b00, 1, 1, 1, 1, 1, 1, 1, 4'd15));
        applyStimulus("post_rst", '0, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0));
        applyStimulus("post_rst_run", lw, mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 4'd0));

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
